ps2_mode_ctrl: RTL
==================

// Module: ps2_mode_ctrl
// PURPOSE
// - Parametrised PS/2 keyboard mode controller: receives PS/2 frames, decodes set-2 make/break/extended codes,
//   and holds a NUM_MODES-way mode register with one-hot LED drive.
// - Sits between the board PS/2 pins and the mode consumers (LED bank, datapath mode select).
// - Frame receiver, scancode decoder and mode register are in one clock domain. Adds framing/parity checks,
//   timeout recovery and a mode-change strobe.
// PARAMETERS
// - NUM_MODES   5       number of selectable modes, keys '1'..'NUM_MODES'; legal 2..9 (elaboration error otherwise)
// - TIMEOUT_CYC 100000  i_clk cycles with no PS/2 falling edge mid-frame before abort (1 ms @ 100 MHz)
// - SYNC_STAGES 2       flip-flop stages on i_ps2_clk / i_ps2_data; legal >= 2
// - MODE_W (localparam) = $clog2(NUM_MODES)
// PORTS
// - i_clk          in   1          system clock (100 MHz nominal); the only clock
// - i_rst_n        in   1          reset, synchronous, active-low
// - i_ps2_clk      in   1          raw PS/2 clock pin, asynchronous
// - i_ps2_data     in   1          raw PS/2 data pin, asynchronous
// - o_mode         out  MODE_W     current mode index, 0..NUM_MODES-1
// - o_led          out  NUM_MODES  one-hot of o_mode
// - o_mode_chg     out  1          1-cycle pulse when o_mode takes a new, different value
// - o_scancode     out  8          last good received byte
// - o_scancode_vld out  1          1-cycle pulse, o_scancode updated
// - o_frame_err    out  1          1-cycle pulse on bad start/parity/stop bit or timeout
// BEHAVIOUR
// - Reset values (i_rst_n=0 at a rising i_clk edge): o_mode=0, o_led=1, all pulses=0, o_scancode=8'h00.
//   RX FSM goes to IDLE; the brk and ext flags clear. A partial frame is discarded.
// - Pins pass through SYNC_STAGES flops. A falling edge is detected from the synced clock (prev=1, cur=0).
//   Data is sampled from the synced data on that same cycle.
// - RX FSM, one sample per falling edge:
//   - IDLE->DATA: on sample 0 (start bit). A start sample of 1 pulses o_frame_err and stays in IDLE.
//   - DATA: 8 bits, LSB first -> PARITY.
//   - PARITY: odd parity over data+parity -> STOP.
//   - STOP: needs a 1.
// - The cycle after the STOP edge is the result cycle:
//   - Good frame: o_scancode is loaded and o_scancode_vld pulses.
//   - Bad parity or stop: o_frame_err pulses and o_scancode holds.
//   - FSM returns to IDLE either way.
// - Timeout: a counter runs while the FSM is not in IDLE and clears on every falling edge. When it reaches
//   TIMEOUT_CYC, the FSM goes to IDLE and o_frame_err pulses. If the timeout and a falling edge land on the
//   same cycle, the edge wins.
// - Decoder, acting on each good byte:
//   - F0: set brk.
//   - E0: set ext.
//   - Any other byte: act on it, then clear brk and ext.
//   - Make code (brk=0, ext=0) for key k in {16,1E,26,25,2E,36,3D,3E,46} -> index 0..8. If index < NUM_MODES,
//     o_mode loads the index.
//   - Break codes, out-of-range keys and unmapped codes leave o_mode unchanged.
// - o_mode, o_led and o_mode_chg update on the cycle after o_scancode_vld. o_mode_chg fires only if the new
//   index differs from the old one, so typematic repeats of the current key never pulse.
// - o_frame_err also clears brk and ext, so decoding resynchronises on the next byte.
// - o_led is registered and always one-hot. An invalid mode is unreachable.
// CONFIGURATION
// - `PS2_MODE_CYCLE_EN` defined:
//   - E0 74 (right arrow, make) sets o_mode = o_mode+1, wrapping NUM_MODES-1 -> 0.
//   - E0 6B (left arrow, make) sets o_mode = o_mode-1, wrapping 0 -> NUM_MODES-1.
//   - o_mode_chg pulses on each arrow press. The arrow break sequences E0 F0 74 and E0 F0 6B are ignored.
// - Not defined: every E0-prefixed code is ignored, and only the number keys select a mode.
// TESTING
// - Reset held 4 cycles, then released -> o_mode=0, o_led=5'b00001, no pulses while the pins idle high.
// - Frame 8'h26 with good parity -> o_scancode_vld pulse with o_scancode=26. Next cycle: o_mode=2,
//   o_led=5'b00100, o_mode_chg pulse.
// - F0,26 then 26 again while mode=2 -> no o_mode_chg. Then 46 with NUM_MODES=5 -> mode stays 2.
// - Frame 8'h1E with bad parity -> o_frame_err pulse, no o_scancode_vld, mode unchanged.
// - PS/2 clock stops after 4 data bits for TIMEOUT_CYC+1 cycles -> o_frame_err, FSM in IDLE.
//   Next good frame 8'h16 -> mode=0.
// - `PS2_MODE_CYCLE_EN`, mode=4, NUM_MODES=5, bytes E0,74 -> mode=0 and o_mode_chg pulses.
//   Then E0,6B -> mode=4.

Source files
------------

// File: rtl/ps2_mode_ctrl.sv
// ps2_mode_ctrl
//   PS/2 keyboard mode controller. Synchronises the raw PS/2 pins, receives
//   11-bit frames (start, 8 data LSB first, odd parity, stop), decodes set-2
//   make/break/extended codes and holds a NUM_MODES-way mode register with a
//   registered one-hot LED drive.
//
//   Optional feature macro: PS2_MODE_CYCLE_EN
//     defined   : E0 74 (right arrow) steps the mode up, E0 6B (left arrow)
//                 steps it down, both wrapping.
//     undefined : every E0-prefixed code is ignored.
//
// Ports
//   i_clk          system clock, the only clock
//   i_rst_n        synchronous active-low reset
//   i_ps2_clk      raw PS/2 clock pin (asynchronous)
//   i_ps2_data     raw PS/2 data pin (asynchronous)
//   o_mode         current mode index 0..NUM_MODES-1
//   o_led          one-hot of o_mode
//   o_mode_chg     1-cycle pulse when o_mode takes a new, different value
//   o_scancode     last good received byte
//   o_scancode_vld 1-cycle pulse, o_scancode updated
//   o_frame_err    1-cycle pulse on bad start/parity/stop bit or timeout
module ps2_mode_ctrl #(
  parameter int NUM_MODES   = 5,
  parameter int TIMEOUT_CYC = 100000,
  parameter int SYNC_STAGES = 2,
  localparam int MODE_W     = $clog2(NUM_MODES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ps2_clk,
  input  logic                 i_ps2_data,
  output logic [MODE_W-1:0]    o_mode,
  output logic [NUM_MODES-1:0] o_led,
  output logic                 o_mode_chg,
  output logic [7:0]           o_scancode,
  output logic                 o_scancode_vld,
  output logic                 o_frame_err
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCNT_W-1:0] TMO_LIMIT = TCNT_W'(TIMEOUT_CYC);
  localparam logic [3:0] NUM_MODES_4 = 4'(NUM_MODES);
  localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NUM_MODES - 1);
  localparam logic [3:0] NO_KEY = 4'hF;

  generate
    if (NUM_MODES < 2 || NUM_MODES > 9) begin : g_bad_num_modes
      $error("ps2_mode_ctrl: NUM_MODES must be 2..9");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("ps2_mode_ctrl: SYNC_STAGES must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  rx_state_t state_q, state_nxt;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_fall, sample;
  logic [7:0]             shift_q;
  logic [2:0]             bit_cnt_q;
  logic                   par_q;
  logic [TCNT_W-1:0]      tmo_cnt_q;
  logic                   timeout_hit;
  logic                   start_err, frame_good, frame_bad;
  logic                   brk_q, ext_q;
  logic [3:0]             key_idx;
  logic [MODE_W-1:0]      mode_nxt;
  logic                   chg_nxt;
  logic [NUM_MODES-1:0]   led_nxt;

  // Pins idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i_ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ps2_fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign sample   = data_sync_q[SYNC_STAGES-1];

  // A falling edge on the same cycle as the limit takes priority.
  assign timeout_hit = (state_q != S_IDLE) && !ps2_fall && (tmo_cnt_q == TMO_LIMIT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (ps2_fall) begin
      case (state_q)
        S_IDLE:   if (!sample) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt = S_IDLE;
    end
  end

  // Frame verdicts; they are registered below so the pulses land on the
  // cycle after the deciding edge.
  always_comb begin
    start_err  = ps2_fall && (state_q == S_IDLE) && sample;
    frame_good = ps2_fall && (state_q == S_STOP) && sample && (^{shift_q, par_q});
    frame_bad  = ps2_fall && (state_q == S_STOP) && !(sample && (^{shift_q, par_q}));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      par_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      if (ps2_fall) begin
        case (state_q)
          S_IDLE:   bit_cnt_q <= 3'd0;
          S_DATA: begin
            shift_q   <= {sample, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          S_PARITY: par_q <= sample;
          default:  ;
        endcase
      end
      if (state_q == S_IDLE || ps2_fall || timeout_hit) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_scancode     <= 8'h00;
      o_scancode_vld <= 1'b0;
      o_frame_err    <= 1'b0;
    end else begin
      o_scancode_vld <= frame_good;
      o_frame_err    <= start_err || frame_bad || timeout_hit;
      if (frame_good) o_scancode <= shift_q;
    end
  end

  // Set-2 make codes for keys '1'..'9'.
  always_comb begin
    case (o_scancode)
      8'h16:   key_idx = 4'd0;
      8'h1E:   key_idx = 4'd1;
      8'h26:   key_idx = 4'd2;
      8'h25:   key_idx = 4'd3;
      8'h2E:   key_idx = 4'd4;
      8'h36:   key_idx = 4'd5;
      8'h3D:   key_idx = 4'd6;
      8'h3E:   key_idx = 4'd7;
      8'h46:   key_idx = 4'd8;
      default: key_idx = NO_KEY;
    endcase
  end

  always_comb begin
    mode_nxt = o_mode;
    chg_nxt  = 1'b0;
    if (o_scancode_vld && !brk_q && !ext_q && key_idx < NUM_MODES_4) begin
      mode_nxt = key_idx[MODE_W-1:0];
      chg_nxt  = (key_idx[MODE_W-1:0] != o_mode);
    end
`ifdef PS2_MODE_CYCLE_EN
    else if (o_scancode_vld && ext_q && !brk_q && o_scancode == 8'h74) begin
      mode_nxt = (o_mode == MAX_MODE) ? '0 : o_mode + 1'b1;
      chg_nxt  = 1'b1;
    end else if (o_scancode_vld && ext_q && !brk_q && o_scancode == 8'h6B) begin
      mode_nxt = (o_mode == '0) ? MAX_MODE : o_mode - 1'b1;
      chg_nxt  = 1'b1;
    end
`endif
    for (int i = 0; i < NUM_MODES; i++) begin
      led_nxt[i] = (mode_nxt == MODE_W'(i));
    end
  end

  // Prefix flags; a framing error drops any half-received sequence.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || o_frame_err) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
    end else if (o_scancode_vld) begin
      if (o_scancode == 8'hF0) begin
        brk_q <= 1'b1;
      end else if (o_scancode == 8'hE0) begin
        ext_q <= 1'b1;
      end else begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_mode     <= '0;
      o_led      <= NUM_MODES'(1);
      o_mode_chg <= 1'b0;
    end else begin
      o_mode     <= mode_nxt;
      o_led      <= led_nxt;
      o_mode_chg <= chg_nxt;
    end
  end

endmodule
